id_ex_stage: RTL and testbench

- ID/EX pipeline register plus operand-forwarding and load-use hazard unit for the 5-stage MIPS datapath.
- Captures decoded operands and controls from ID and holds them for one cycle.
- Drives the ALU's op, din1_alu and din2_alu inputs, with EX/MEM and MEM/WB results forwarded into those operands.
- Detects load-use hazards and inserts bubbles.

---
 rtl/id_ex_stage.sv | 151 +++++++++++++++
 tb/tb_id_ex_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS datapath.
// Holds decoded operands and controls for one cycle. Forwards EX/MEM and
// MEM/WB results into the ALU operands. Raises load_use when the instruction
// in ID needs a value that the load now in EX has not fetched yet.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int FWD_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [3:0]        id_alu_op,
    input  logic              id_alu_src,
    input  logic              id_reg_dst,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    output logic [3:0]        op,
    output logic [DATA_W-1:0] din1_alu,
    output logic [DATA_W-1:0] din2_alu,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_dest,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              ex_valid,
    output logic              load_use
);

    // Everything the stage holds between ID and EX. An all-zero word is a
    // bubble: not valid, no writes, op AND on zero operands.
    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              alu_src;
        logic [3:0]        alu_op;
        logic [REG_AW-1:0] dest;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
    } pipe_t;

    pipe_t pipe_q;
    pipe_t id_word;

    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    // Pick the freshest copy of a source register. EX/MEM is younger than
    // MEM/WB, so it is checked first; $0 is hard-wired and never forwarded.
    function automatic logic [DATA_W-1:0] forward(
        input logic [REG_AW-1:0] src,
        input logic [DATA_W-1:0] reg_val
    );
        logic [DATA_W-1:0] sel;
        sel = reg_val;
        if (FWD_EN != 0) begin
            if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == src))
                sel = exmem_result;
            else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == src))
                sel = memwb_result;
        end
        return sel;
    endfunction

    // Assemble the word captured from ID; an empty ID slot carries no controls.
    always_comb begin
        // NOTE: every field gets a default first so this block can never infer a latch.
        id_word            = '0;
        id_word.valid      = id_valid;
        id_word.reg_write  = id_valid & id_reg_write;
        id_word.mem_read   = id_valid & id_mem_read;
        id_word.mem_write  = id_valid & id_mem_write;
        id_word.mem_to_reg = id_valid & id_mem_to_reg;
        id_word.alu_src    = id_valid & id_alu_src;
        id_word.alu_op     = id_valid ? id_alu_op : 4'b0000;
        id_word.dest       = id_reg_dst ? id_rd : id_rt;
        id_word.rs         = id_rs;
        id_word.rt         = id_rt;
        id_word.rs_data    = id_rs_data;
        id_word.rt_data    = id_rt_data;
        id_word.imm        = id_imm;
    end

    // Load-use: the load in EX writes a register that ID is about to read.
    always_comb begin
        load_use = pipe_q.valid & pipe_q.mem_read & id_valid &
                   (pipe_q.dest != '0) &
                   ((pipe_q.dest == id_rs) | (pipe_q.dest == id_rt));
    end

    // Pipeline register: flush beats stall, stall beats a load-use bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the whole stage, data included, is reset so outputs are defined at once.
        if (!rst_n) begin
            pipe_q <= '0;
        end else if (flush) begin
            // NOTE: non-blocking assignment for all sequential state.
            pipe_q <= '0;
        end else if (stall) begin
            pipe_q <= pipe_q;
        end else if (load_use) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= id_word;
        end
    end

    // Operand forwarding from the registered rs/rt specifiers.
    always_comb begin
        fwd_rs = forward(pipe_q.rs, pipe_q.rs_data);
        fwd_rt = forward(pipe_q.rt, pipe_q.rt_data);
    end

    // Drive the ALU and the downstream controls.
    always_comb begin
        op            = pipe_q.alu_op;
        din1_alu      = fwd_rs;
        din2_alu      = pipe_q.alu_src ? pipe_q.imm : fwd_rt;
        ex_store_data = fwd_rt;
        ex_dest       = pipe_q.dest;
        ex_reg_write  = pipe_q.reg_write;
        ex_mem_read   = pipe_q.mem_read;
        ex_mem_write  = pipe_q.mem_write;
        ex_mem_to_reg = pipe_q.mem_to_reg;
        ex_valid      = pipe_q.valid;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, capture, forwarding priority,
// load-use bubble, stall/flush and the immediate path.
module tb_id_ex_stage;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              stall, flush, id_valid;
    logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm;
    logic [REG_AW-1:0] id_rs, id_rt, id_rd;
    logic [3:0]        id_alu_op;
    logic              id_alu_src, id_reg_dst;
    logic              id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic              exmem_reg_write, memwb_reg_write;
    logic [REG_AW-1:0] exmem_rd, memwb_rd;
    logic [DATA_W-1:0] exmem_result, memwb_result;
    logic [3:0]        op;
    logic [DATA_W-1:0] din1_alu, din2_alu, ex_store_data;
    logic [REG_AW-1:0] ex_dest;
    logic              ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic              ex_valid, load_use;

    int n_checks = 0;
    int n_fail   = 0;

    id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
        .exmem_result(exmem_result), .memwb_reg_write(memwb_reg_write),
        .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .op(op), .din1_alu(din1_alu), .din2_alu(din2_alu),
        .ex_store_data(ex_store_data), .ex_dest(ex_dest),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_valid(ex_valid), .load_use(load_use)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 0; flush = 0; id_valid = 0;
        id_rs_data = '0; id_rt_data = '0; id_imm = '0;
        id_rs = '0; id_rt = '0; id_rd = '0;
        id_alu_op = 4'b0000; id_alu_src = 0; id_reg_dst = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
        exmem_reg_write = 0; exmem_rd = '0; exmem_result = '0;
        memwb_reg_write = 0; memwb_rd = '0; memwb_result = '0;
    endtask

    // R-type ID slot: rd = rs op rt.
    task automatic load_rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                              input logic [31:0] rs_val, input logic [31:0] rt_val,
                              input logic [3:0] alu_op);
        id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = rs_val; id_rt_data = rt_val; id_imm = '0;
        id_alu_op = alu_op; id_alu_src = 0; id_reg_dst = 1;
        id_reg_write = 1; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
    endtask

    initial begin
        clear_inputs();
        rst_n = 0;
        #1;
        check("reset_valid", {31'b0, ex_valid}, 32'h0);
        check("reset_op", {28'b0, op}, 32'h0);
        #12 rst_n = 1;

        // Reset asserted mid-cycle clears an occupied stage without an edge.
        load_rtype(5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 4'b0001);
        tick();
        check("pre_reset_valid", {31'b0, ex_valid}, 32'h1);
        #2 rst_n = 0;
        #1;
        check("async_reset_valid", {31'b0, ex_valid}, 32'h0);
        check("async_reset_din1", din1_alu, 32'h0);
        check("async_reset_dest", {27'b0, ex_dest}, 32'h0);
        check("async_reset_ctrl", {28'b0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, 32'h0);
        check("async_reset_load_use", {31'b0, load_use}, 32'h0);
        #1 rst_n = 1;

        // Plain capture: first edge after release captures ID.
        load_rtype(5'd1, 5'd2, 5'd9, 32'd5, 32'd7, 4'b0010);
        tick();
        check("cap_op", {28'b0, op}, 32'h2);
        check("cap_din1", din1_alu, 32'd5);
        check("cap_din2", din2_alu, 32'd7);
        check("cap_dest", {27'b0, ex_dest}, 32'd9);
        check("cap_valid", {31'b0, ex_valid}, 32'h1);
        check("cap_reg_write", {31'b0, ex_reg_write}, 32'h1);

        // Forwarding priority on rs=3.
        load_rtype(5'd3, 5'd4, 5'd5, 32'h11, 32'h44, 4'b0110);
        tick();
        clear_inputs();
        exmem_reg_write = 1; exmem_rd = 5'd3; exmem_result = 32'hAA;
        memwb_reg_write = 1; memwb_rd = 5'd3; memwb_result = 32'hBB;
        #1 check("fwd_exmem_wins", din1_alu, 32'hAA);
        check("fwd_rt_untouched", din2_alu, 32'h44);
        exmem_reg_write = 0;
        #1 check("fwd_memwb", din1_alu, 32'hBB);
        memwb_reg_write = 0;
        #1 check("fwd_none", din1_alu, 32'h11);

        // Register 0 is never forwarded.
        load_rtype(5'd0, 5'd4, 5'd5, 32'h22, 32'h44, 4'b0000);
        tick();
        clear_inputs();
        exmem_reg_write = 1; exmem_rd = 5'd0; exmem_result = 32'hAA;
        memwb_reg_write = 1; memwb_rd = 5'd0; memwb_result = 32'hBB;
        #1 check("fwd_reg0", din1_alu, 32'h22);
        clear_inputs();

        // Load-use: lw $8, 4($1) in EX, add $10, $8, $2 in ID.
        id_valid = 1; id_rs = 5'd1; id_rt = 5'd8; id_rd = 5'd0; id_reg_dst = 0;
        id_rs_data = 32'h1000; id_imm = 32'd4; id_alu_src = 1; id_alu_op = 4'b0010;
        id_reg_write = 1; id_mem_read = 1; id_mem_to_reg = 1;
        tick();
        check("lw_dest", {27'b0, ex_dest}, 32'd8);
        check("lw_din2_imm", din2_alu, 32'd4);
        load_rtype(5'd8, 5'd2, 5'd10, 32'h100, 32'h3, 4'b0010);
        #1 check("load_use_set", {31'b0, load_use}, 32'h1);
        tick();
        check("lu_bubble_valid", {31'b0, ex_valid}, 32'h0);
        check("lu_bubble_mem_read", {31'b0, ex_mem_read}, 32'h0);
        check("lu_bubble_op", {28'b0, op}, 32'h0);
        check("lu_cleared", {31'b0, load_use}, 32'h0);
        memwb_reg_write = 1; memwb_rd = 5'd8; memwb_result = 32'h55;
        tick();
        check("lu_replay_valid", {31'b0, ex_valid}, 32'h1);
        check("lu_replay_dest", {27'b0, ex_dest}, 32'd10);
        check("lu_replay_fwd", din1_alu, 32'h55);
        memwb_reg_write = 0;

        // Stall for 3 cycles while ID changes: stage frozen.
        stall = 1;
        load_rtype(5'd6, 5'd7, 5'd12, 32'h66, 32'h77, 4'b1100);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall_dest_%0d", i), {27'b0, ex_dest}, 32'd10);
            check($sformatf("stall_op_%0d", i), {28'b0, op}, 32'h2);
            check($sformatf("stall_din1_%0d", i), din1_alu, 32'h100);
        end
        flush = 1;
        tick();
        check("flush_valid", {31'b0, ex_valid}, 32'h0);
        check("flush_op", {28'b0, op}, 32'h0);
        check("flush_reg_write", {31'b0, ex_reg_write}, 32'h0);
        check("flush_data", din1_alu, 32'h0);
        clear_inputs();

        // Immediate path with forwarded rt: sw $6, -4($5).
        id_valid = 1; id_rs = 5'd5; id_rt = 5'd6; id_rd = 5'd0; id_reg_dst = 0;
        id_rs_data = 32'h2000; id_rt_data = 32'h1; id_imm = 32'hFFFF_FFFC;
        id_alu_src = 1; id_alu_op = 4'b0010; id_mem_write = 1;
        tick();
        clear_inputs();
        exmem_reg_write = 1; exmem_rd = 5'd6; exmem_result = 32'hDEAD;
        memwb_reg_write = 1; memwb_rd = 5'd5; memwb_result = 32'h3000;
        #1 check("imm_din2", din2_alu, 32'hFFFF_FFFC);
        check("imm_store_fwd", ex_store_data, 32'hDEAD);
        check("imm_din1_memwb", din1_alu, 32'h3000);
        check("imm_dest_rt", {27'b0, ex_dest}, 32'd6);
        check("imm_mem_write", {31'b0, ex_mem_write}, 32'h1);
        check("imm_reg_write", {31'b0, ex_reg_write}, 32'h0);

        // Empty ID slot captures with all controls low.
        clear_inputs();
        id_reg_write = 1; id_mem_write = 1; id_alu_op = 4'b0111;
        tick();
        check("invalid_valid", {31'b0, ex_valid}, 32'h0);
        check("invalid_ctrl", {28'b0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
